// File: rtl/fft16_sample_loader.sv
// fft16_sample_loader: gathers 16 complex samples into a bit-reversed buffer,
// then presents them as 8 adjacent butterfly pairs for the first radix-2 stage.
//
// Ports
//   i_clk, i_rst_n        rising-edge clock, asynchronous active-low reset
//   i_valid, i_re, i_im   upstream sample stream (accepted when o_ready=1)
//   o_ready               loader accepts a sample this cycle
//   o_in0_re/o_in0_im     butterfly upper input  (buffer[2p])
//   o_in1_re/o_in1_im     butterfly lower input  (buffer[2p+1])
//   o_pair_idx            pair index p (0..7)
//   o_pair_valid          pair outputs valid
//   i_pair_ack            downstream consumed the pair
//   o_frame_done          one-cycle pulse after the last pair is acknowledged
module fft16_sample_loader #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRACTION  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [WORD_SIZE-1:0] i_re,
    input  logic [WORD_SIZE-1:0] i_im,
    output logic                 o_ready,
    output logic [WORD_SIZE-1:0] o_in0_re,
    output logic [WORD_SIZE-1:0] o_in0_im,
    output logic [WORD_SIZE-1:0] o_in1_re,
    output logic [WORD_SIZE-1:0] o_in1_im,
    output logic [2:0]           o_pair_idx,
    output logic                 o_pair_valid,
    input  logic                 i_pair_ack,
    output logic                 o_frame_done
);

    localparam int unsigned DEPTH = 16;

    // Data passes through unscaled; the fraction width only has to be sane.
    if (FRACTION >= WORD_SIZE) begin : g_bad_fraction
        $error("FRACTION must be smaller than WORD_SIZE");
    end

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [2:0]           p_q;
    logic                 ready_q;
    logic                 pvalid_q;
    logic                 done_q;
    logic [2:0]           idx_q;
    logic [WORD_SIZE-1:0] in0_re_q;
    logic [WORD_SIZE-1:0] in0_im_q;
    logic [WORD_SIZE-1:0] in1_re_q;
    logic [WORD_SIZE-1:0] in1_im_q;

    logic [WORD_SIZE-1:0] mem_re [DEPTH];
    logic [WORD_SIZE-1:0] mem_im [DEPTH];

    logic       accept_c;
    logic [3:0] wr_idx_c;
    logic [2:0] p_nxt_c;
    logic [3:0] rd0_idx_c;
    logic [3:0] rd1_idx_c;

    // Handshake, bit-reversed write address and next-pair read addresses.
    always_comb begin
        accept_c  = (state_q == ST_LOAD) && ready_q && i_valid;
        wr_idx_c  = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};
        p_nxt_c   = p_q + 3'd1;
        rd0_idx_c = {p_nxt_c, 1'b0};
        rd1_idx_c = {p_nxt_c, 1'b1};
    end

    // Sample buffer; contents survive reset, a new frame overwrites every entry.
    always_ff @(posedge i_clk) begin
        if (accept_c) begin
            mem_re[wr_idx_c] <= i_re;
            mem_im[wr_idx_c] <= i_im;
        end
    end

    // Load/emit controller with registered pair outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_LOAD;
            cnt_q    <= 4'd0;
            p_q      <= 3'd0;
            ready_q  <= 1'b0;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= 3'd0;
            in0_re_q <= '0;
            in0_im_q <= '0;
            in1_re_q <= '0;
            in1_im_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_LOAD: begin
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        if (cnt_q == 4'd15) begin
                            // Sample 15 lands in entry 15, so pair 0 is already complete.
                            state_q  <= ST_EMIT;
                            cnt_q    <= 4'd0;
                            ready_q  <= 1'b0;
                            pvalid_q <= 1'b1;
                            p_q      <= 3'd0;
                            idx_q    <= 3'd0;
                            in0_re_q <= mem_re[0];
                            in0_im_q <= mem_im[0];
                            in1_re_q <= mem_re[1];
                            in1_im_q <= mem_im[1];
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (i_pair_ack) begin
                        if (p_q == 3'd7) begin
                            state_q  <= ST_LOAD;
                            pvalid_q <= 1'b0;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                            p_q      <= 3'd0;
                            idx_q    <= 3'd0;
                        end else begin
                            p_q      <= p_nxt_c;
                            idx_q    <= p_nxt_c;
                            in0_re_q <= mem_re[rd0_idx_c];
                            in0_im_q <= mem_im[rd0_idx_c];
                            in1_re_q <= mem_re[rd1_idx_c];
                            in1_im_q <= mem_im[rd1_idx_c];
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_pair_valid = pvalid_q;
    assign o_frame_done = done_q;
    assign o_pair_idx   = idx_q;
    assign o_in0_re     = in0_re_q;
    assign o_in0_im     = in0_im_q;
    assign o_in1_re     = in1_re_q;
    assign o_in1_im     = in1_im_q;

endmodule

// File: tb/tb_fft16_sample_loader.sv
// Bench for fft16_sample_loader: randomized sample/ack traffic checked against
// a frame-level model (pair p holds arrivals bitrev(2p) and bitrev(2p+1)).
module tb_fft16_sample_loader;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [W-1:0] i_re;
    logic [W-1:0] i_im;
    logic         o_ready;
    logic [W-1:0] o_in0_re;
    logic [W-1:0] o_in0_im;
    logic [W-1:0] o_in1_re;
    logic [W-1:0] o_in1_im;
    logic [2:0]   o_pair_idx;
    logic         o_pair_valid;
    logic         i_pair_ack;
    logic         o_frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [W-1:0] f_re [16];
    logic [W-1:0] f_im [16];

    fft16_sample_loader #(.WORD_SIZE(W), .FRACTION(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_re         (i_re),
        .i_im         (i_im),
        .o_ready      (o_ready),
        .o_in0_re     (o_in0_re),
        .o_in0_im     (o_in0_im),
        .o_in1_re     (o_in1_re),
        .o_in1_im     (o_in1_im),
        .o_pair_idx   (o_pair_idx),
        .o_pair_valid (o_pair_valid),
        .i_pair_ack   (i_pair_ack),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arrival number whose sample ends up in buffer slot x.
    function automatic int bitrev4(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < 4; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 16; k++) begin
            f_re[k] = 16'($urandom);
            f_im[k] = 16'($urandom);
        end
    endtask

    // Loads f_re/f_im as one frame, then drains and checks all 8 pairs.
    task automatic run_frame(input int valid_pct, input int ack_pct, input bit stall3);
        int  k = 0;
        int  p = 0;
        int  guard = 0;
        int  stall = 0;
        bit  v;
        bit  a;
        while (k < 16 && guard < 2000) begin
            check("ready_in_load", 32'(o_ready), 32'd1);
            check("pvalid_in_load", 32'(o_pair_valid), 32'd0);
            v = ($urandom_range(99) < valid_pct);
            i_valid    = v;
            i_re       = v ? f_re[k] : 16'($urandom);
            i_im       = v ? f_im[k] : 16'($urandom);
            i_pair_ack = 1'($urandom_range(1));
            if (v && o_ready) k++;
            guard++;
            @(negedge clk);
        end
        i_valid    = 1'b0;
        i_pair_ack = 1'b0;
        if (k < 16) check("load_timeout", 32'(k), 32'd16);
        check("pvalid_latency", 32'(o_pair_valid), 32'd1);
        check("ready_in_emit", 32'(o_ready), 32'd0);
        guard = 0;
        while (p < 8 && guard < 500) begin
            check("pair_valid", 32'(o_pair_valid), 32'd1);
            check("pair_idx", 32'(o_pair_idx), 32'(p));
            check("in0_re", 32'(o_in0_re), 32'(f_re[bitrev4(2 * p)]));
            check("in0_im", 32'(o_in0_im), 32'(f_im[bitrev4(2 * p)]));
            check("in1_re", 32'(o_in1_re), 32'(f_re[bitrev4(2 * p + 1)]));
            check("in1_im", 32'(o_in1_im), 32'(f_im[bitrev4(2 * p + 1)]));
            if (stall3 && p == 3 && stall < 5) begin
                a = 1'b0;
                stall++;
            end else begin
                a = ($urandom_range(99) < ack_pct);
            end
            i_pair_ack = a;
            // Junk samples during emit must be dropped, including on the final ack.
            i_valid = (p == 7 && a) ? 1'b1 : 1'($urandom_range(1));
            i_re    = 16'h7777;
            i_im    = 16'h7777;
            if (a) p++;
            guard++;
            @(negedge clk);
        end
        i_pair_ack = 1'b0;
        i_valid    = 1'b0;
        if (p < 8) check("emit_timeout", 32'(p), 32'd8);
        if (stall3) check("stall_cycles", 32'(stall), 32'd5);
        check("frame_done", 32'(o_frame_done), 32'd1);
        check("pvalid_after", 32'(o_pair_valid), 32'd0);
        check("ready_after", 32'(o_ready), 32'd1);
        check("idx_after", 32'(o_pair_idx), 32'd0);
        @(negedge clk);
        check("done_width", 32'(o_frame_done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_pair_ack = 1'b0;
        i_re       = '0;
        i_im       = '0;
        repeat (3) @(negedge clk);

        // Reset values with the clock running.
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_pvalid", 32'(o_pair_valid), 32'd0);
        check("rst_done", 32'(o_frame_done), 32'd0);
        check("rst_idx", 32'(o_pair_idx), 32'd0);
        check("rst_data", {o_in0_re, o_in0_im} | {o_in1_re, o_in1_im}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready), 32'd1);

        // Ordering: re=k, im=-k, back-to-back with ack held high.
        for (int k = 0; k < 16; k++) begin
            f_re[k] = 16'(k);
            f_im[k] = 16'(-k);
        end
        done_cnt = 0;
        run_frame(100, 100, 1'b0);
        check("done_count_order", 32'(done_cnt), 32'd1);

        // Backpressure at p=3.
        fill_random();
        run_frame(100, 100, 1'b1);

        // Upstream gaps and random ack.
        for (int n = 0; n < 3; n++) begin
            fill_random();
            run_frame(50, 70, 1'b0);
        end

        // Reset after 9 accepted samples discards the partial frame.
        fill_random();
        for (int k = 0; k < 9; k++) begin
            i_valid = 1'b1;
            i_re    = f_re[k];
            i_im    = f_im[k];
            @(negedge clk);
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_ready", 32'(o_ready), 32'd0);
        check("midrst_pvalid", 32'(o_pair_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        run_frame(60, 80, 1'b0);

        // Back-to-back frames, second one constant.
        done_cnt = 0;
        fill_random();
        run_frame(100, 100, 1'b0);
        for (int k = 0; k < 16; k++) begin
            f_re[k] = 16'h0100;
            f_im[k] = 16'hFF00;
        end
        run_frame(100, 100, 1'b0);
        check("done_count_b2b", 32'(done_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
